// File: rtl/data_mem_responder.sv
// MEM-stage data responder: direct-mapped, write-through, no-write-allocate cache in front of
// a multi-cycle backing word memory. Define DMEM_WRITE_BUFFER_EN for a single-entry posted write buffer.
module data_mem_responder #(
    parameter int LINES     = 16,
    parameter int MISS_LAT  = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MEM,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        BUSY
);
    localparam int WA_W  = $clog2(MEM_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WA_W - 2 - IDX_W;
    localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_LAT - 1);

    typedef enum logic [1:0] {IDLE, MISS_WAIT, REFILL, WRITE} state_t;

    logic [WA_W-1:0]  word_addr;
    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             unused_addr_bits;

    assign word_addr        = Addr[WA_W+1:2];
    assign offset           = word_addr[1:0];
    assign index            = word_addr[IDX_W+1:2];
    assign tag              = word_addr[WA_W-1:IDX_W+2];
    assign unused_addr_bits = ^{Addr[31:WA_W+2], Addr[1:0]};

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags      [LINES];
    logic [31:0]      line_data [LINES][4];
    logic [31:0]      mem       [MEM_WORDS];

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       beat, beat_nxt;

    logic             hit;
    logic             busy;
    logic [31:0]      rdata;
    logic             fill_we;
    logic             cache_wr;
    logic             mem_we;
    logic [WA_W-1:0]  mem_waddr;
    logic [31:0]      mem_wdata;
    logic             wb_block;

    assign hit = valid[index] && (tags[index] == tag);

`ifdef DMEM_WRITE_BUFFER_EN
    logic             wb_vld;
    logic             wb_load;
    logic [CNT_W-1:0] wb_cnt;
    logic [WA_W-1:0]  wb_addr;
    logic [31:0]      wb_data;

    // A pending posted write must reach memory before any refill reads it.
    assign wb_block = wb_vld;
`else
    assign wb_block = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beat_nxt  = beat;
        busy      = 1'b0;
        rdata     = '0;
        fill_we   = 1'b0;
        cache_wr  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = word_addr;
        mem_wdata = Wdata;
`ifdef DMEM_WRITE_BUFFER_EN
        wb_load   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (MEM[0]) begin
                    if (hit) begin
                        rdata = line_data[index][offset];
                    end else begin
                        busy = 1'b1;
                        if (!wb_block) begin
                            beat_nxt = 2'd0;
                            // The accept cycle counts as the first wait cycle.
                            if (MISS_LAT == 1) begin
                                state_nxt = REFILL;
                            end else begin
                                state_nxt = MISS_WAIT;
                                cnt_nxt   = CNT_LOAD;
                            end
                        end
                    end
                end else if (MEM[1]) begin
`ifdef DMEM_WRITE_BUFFER_EN
                    if (wb_vld) begin
                        busy = 1'b1;
                    end else begin
                        wb_load  = 1'b1;
                        cache_wr = hit;
                    end
`else
                    busy      = 1'b1;
                    cache_wr  = hit;
                    state_nxt = WRITE;
                    cnt_nxt   = CNT_LOAD;
`endif
                end
            end
            MISS_WAIT: begin
                busy    = 1'b1;
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = REFILL;
                    beat_nxt  = 2'd0;
                end
            end
            REFILL: begin
                busy     = 1'b1;
                fill_we  = 1'b1;
                beat_nxt = beat + 2'd1;
                if (beat == 2'd3) state_nxt = IDLE;
            end
            WRITE: begin
                if (cnt == '0) begin
                    mem_we    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    busy    = 1'b1;
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef DMEM_WRITE_BUFFER_EN
        if (wb_vld && wb_cnt == '0) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr;
            mem_wdata = wb_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            beat  <= '0;
            valid <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            beat  <= beat_nxt;
            if (fill_we && beat == 2'd3) valid[index] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; line contents are qualified by valid.
    always_ff @(posedge clk) begin
        if (fill_we) line_data[index][beat] <= mem[{tag, index, beat}];
        if (fill_we && beat == 2'd3) tags[index] <= tag;
        if (cache_wr) line_data[index][offset] <= Wdata;
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

`ifdef DMEM_WRITE_BUFFER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld <= 1'b0;
            wb_cnt <= '0;
        end else if (wb_load) begin
            wb_vld  <= 1'b1;
            wb_cnt  <= CNT_LOAD;
            wb_addr <= word_addr;
            wb_data <= Wdata;
        end else if (wb_vld) begin
            if (wb_cnt == '0) wb_vld <= 1'b0;
            else              wb_cnt <= wb_cnt - CNT_ONE;
        end
    end
`endif

    assign BUSY  = busy & ~rst;
    assign Rdata = rst ? 32'h0 : rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + random bench for data_mem_responder against a word-array / line-tag reference model.
module tb_data_mem_responder;
    localparam int LINES     = 16;
    localparam int MISS_LAT  = 4;
    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  MEM;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        BUSY;

    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;
    longint wb_free = 0;

    logic [31:0] ref_mem   [MEM_WORDS];
    bit          ref_valid [LINES];
    int          ref_tag   [LINES];

    data_mem_responder #(.LINES(LINES), .MISS_LAT(MISS_LAT), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .MEM(MEM), .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata), .BUSY(BUSY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2) % MEM_WORDS;
    endfunction

    // Issue one request (called just after a rising edge) and check stall length and load data.
    task automatic req(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d, input string tag);
        int     w, ln, tg, stall, exp_stall, wb_wait;
        bit     hit;
        longint s;
        w   = widx(a);
        ln  = (w / 4) % LINES;
        tg  = w / (4 * LINES);
        hit = ref_valid[ln] && ref_tag[ln] == tg;
        MEM = m; Addr = a; Wdata = d;
        @(negedge clk);
        s = cyc;
        stall = 0;
        while (BUSY && stall < 200) begin
            stall++;
            @(negedge clk);
        end
        wb_wait = (wb_free > s) ? int'(wb_free - s) : 0;
        if (m[0]) begin
            exp_stall = hit ? 0 : wb_wait + MISS_LAT + 4;
        end else begin
`ifdef DMEM_WRITE_BUFFER_EN
            exp_stall = wb_wait;
`else
            exp_stall = MISS_LAT;
`endif
        end
        chk({tag, " stall"}, stall, exp_stall);
        if (m[0]) begin
            chk({tag, " rdata"}, Rdata, ref_mem[w]);
            ref_valid[ln] = 1'b1;
            ref_tag[ln]   = tg;
        end else begin
            ref_mem[w] = d;
`ifdef DMEM_WRITE_BUFFER_EN
            wb_free = cyc + MISS_LAT + 1;
`endif
        end
        @(posedge clk); #1;
        MEM = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, v;
        rst = 1'b1; MEM = 2'b01; Addr = 32'h100; Wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            dut.mem[i] = v;
            ref_mem[i] = v;
        end
        dut.mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'b0, BUSY}, 32'h0);
        chk("reset rdata", Rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; MEM = 2'b00;
        @(negedge clk);
        chk("idle busy", {31'b0, BUSY}, 32'h0);
        chk("idle rdata", Rdata, 32'h0);
        @(posedge clk); #1;

        req(2'b01, 32'h100, 32'h0, "first load miss");
        req(2'b01, 32'h104, 32'h0, "same line hit");
        req(2'b10, 32'h100, 32'h12345678, "store hit");
        req(2'b01, 32'h100, 32'h0, "load after store");
        idle(MISS_LAT + 2);
        chk("backing 0x40", dut.mem[32'h40], 32'h12345678);

        req(2'b10, 32'h200, 32'hA5A5_0200, "store miss");
        idle(MISS_LAT + 2);
        chk("backing 0x80", dut.mem[32'h80], ref_mem[32'h80]);
        req(2'b01, 32'h200, 32'h0, "load after store miss");

        req(2'b01, 32'h000, 32'h0, "conflict a");
        req(2'b01, 32'h100, 32'h0, "conflict b");
        req(2'b01, 32'h000, 32'h0, "conflict a again");
        req(2'b11, 32'h1000, 32'h0, "wrapped load hit");

        req(2'b10, 32'h004, 32'hCAFE_0004, "store then");
        req(2'b01, 32'h004, 32'h0, "immediate load");
        req(2'b10, 32'h008, 32'hCAFE_0008, "store first");
        req(2'b10, 32'h00C, 32'hCAFE_000C, "store second");
        idle(MISS_LAT + 2);

        // Reset in the cycle of the third refill beat.
        a = 32'h300;
        MEM = 2'b01; Addr = a;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid-refill reset busy", {31'b0, BUSY}, 32'h0);
        chk("mid-refill reset rdata", Rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        wb_free = 0;
        req(2'b01, a, 32'h0, "load after reset");

        for (int i = 0; i < 60; i++) begin
            a = ({22'b0, 8'($urandom_range(0, 255)), 2'b00})
              | (32'($urandom_range(0, 7)) << 12) | 32'($urandom_range(0, 3));
            req(2'($urandom_range(1, 3)), a, $urandom, "random");
        end
        idle(MISS_LAT + 2);
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 255));
            chk("random backing", dut.mem[a], ref_mem[a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM stage: accepts load/store requests (MEM, Addr, Wdata) and returns Rdata.
- Asserts BUSY to stall the pipeline while a request cannot complete.
- Contains a direct-mapped, write-through, no-write-allocate cache with 4-word lines, in front of an internal multi-cycle backing word memory.
- Replaces the single-cycle data memory behind the MEM stage's stall input.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2).
- MISS_LAT, 4, backing-memory access latency in cycles before first refill beat, or for a write (≥1).
- MEM_WORDS, 1024, backing memory depth in 32-bit words (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- MEM  in  2  request: bit0 = load, bit1 = store; 2'b00 = idle; 2'b11 is treated as a load only.
- Addr  in  32  byte address; bits [1:0] ignored; word index Addr[log2(MEM_WORDS)+1:2].
- Wdata  in  32  store data.
- Rdata  out  32  load data; valid in any cycle with MEM[0]=1 and BUSY=0, otherwise 32'h0.
- BUSY  out  1  stall; requester holds MEM/Addr/Wdata stable while 1.

Behaviour:
- Address split:
  - offset = Addr[3:2]
  - index = Addr[3+log2(LINES):4]
  - tag = remaining bits up to the word-index MSB
- Per line: valid bit, tag, 4 data words.
- FSM states: IDLE, MISS_WAIT, REFILL, WRITE.
- IDLE:
  - Load hit: BUSY=0 combinationally; Rdata = line word, same cycle; zero-latency.
  - Load miss: BUSY=1 in the same cycle (combinational); counter := MISS_LAT-1; go to MISS_WAIT.
  - Store: BUSY=1 same cycle. Go to WRITE with counter := MISS_LAT-1. On a hit, the cache word updates on the first WRITE cycle. On a miss, the cache is unchanged.
  - MEM=00: BUSY=0, Rdata=0, stay in IDLE.
- MISS_WAIT: decrement counter; at 0 go to REFILL, beat := 0.
- REFILL:
  - One word per cycle, beats 0..3 in order, read from backing memory at {tag,index,beat}.
  - After beat 3: set valid and tag, return to IDLE.
  - The IDLE cycle then hits, with BUSY=0 and Rdata valid.
  - Load-miss latency: BUSY high for MISS_LAT+4 cycles.
- WRITE: decrement counter. At 0, write Wdata to backing memory, drop BUSY that same cycle, return to IDLE next cycle. Store BUSY duration = MISS_LAT cycles.
- A new request is only evaluated in IDLE.
- Backing memory contents are not cleared by reset. The bench preloads them via hierarchical access.
- Reset (any state, including mid-refill or mid-write):
  - All valid bits cleared, FSM to IDLE, counters 0.
  - BUSY=0, Rdata=0.
  - An in-flight backing write is discarded.
- Boundaries:
  - Addr above MEM_WORDS wraps (upper bits ignored).
  - A store to a line that is mid-refill cannot occur (requests are only taken in IDLE).
  - Back-to-back loads to the same line: first misses, second hits.

Optional Feature:
- Macro: DMEM_WRITE_BUFFER_EN.
- With the macro:
  - A single-entry write buffer (addr, data, valid) is present.
  - A store with the buffer empty completes with BUSY=0 in the accept cycle: buffer is loaded and the cache is updated on a hit.
  - The buffer drains to backing memory after MISS_LAT cycles, concurrently with subsequent hits.
  - A store while the buffer is full stalls until it drains.
  - A load miss stalls until the buffer drains, then starts MISS_WAIT; this preserves ordering.
  - Reset discards the buffer.
- Without the macro: stores behave as in WRITE above, with no buffer.

Test Plan:
- Reset, then MEM=00 → BUSY=0, Rdata=0; after a load request, all lines are invalid (miss).
- Preload word 0x40=0xDEADBEEF, load Addr=0x100 → BUSY high 8 cycles (MISS_LAT=4), then Rdata=0xDEADBEEF with BUSY=0; immediate load Addr=0x104 → hit, 0 stall.
- Store Addr=0x100, Wdata=0x12345678 after line cached → BUSY 4 cycles; following load 0x100 hits with 0x12345678; backing word 0x40=0x12345678.
- Store to uncached Addr=0x200 → backing updated, line not allocated; next load 0x200 misses (8-cycle BUSY) and returns the stored value.
- Conflict: load 0x000 then 0x100 with LINES=16 (same index 0, different tags) → second evicts first; reload 0x000 misses again.
- Assert rst during REFILL beat 2 → next cycle BUSY=0, same load then misses fully (8 cycles). With DMEM_WRITE_BUFFER_EN: store then immediate load hit → 0 stall; store, store → second stalls until the first drains.
